// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core.
// It holds the PC, the instruction register, the ALU and the branch logic, and drives the register file.
module cpu_sequencer #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clock,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [15:0]         imem_data,
   output logic [2:0]          rs_addr,
   output logic [2:0]          rt_addr,
   output logic [2:0]          rd_addr,
   output logic                rf_write,
   output logic [15:0]         rf_wdata,
   input  logic [15:0]         rs_data,
   input  logic [15:0]         rt_data,
   output logic                halted,
   output logic                illegal
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_HALTED
   } state_t;

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [15:0]         r_ir;
   logic [15:0]         r_result;
   logic                r_rf_write;
   logic                r_halted;
   logic                r_illegal;

   logic [3:0]          w_op;
   logic [15:0]         w_imm6;
   logic [15:0]         w_alu;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_br_tgt;
   logic [PC_WIDTH-1:0] w_jmp_tgt;

   assign w_op      = r_ir[15:12];
   assign w_imm6    = {{10{r_ir[5]}}, r_ir[5:0]};
   assign w_pc_inc  = r_pc + PC_WIDTH'(1);
   // Branch offset is relative to the already-incremented PC; wraps mod 2^PC_WIDTH.
   assign w_br_tgt  = w_pc_inc + PC_WIDTH'(w_imm6);
   assign w_jmp_tgt = PC_WIDTH'(r_ir[7:0]);

   assign imem_addr = r_pc;
   assign rs_addr   = r_ir[8:6];
   assign rt_addr   = r_ir[5:3];
   assign rd_addr   = r_ir[11:9];
   assign rf_write  = r_rf_write;
   assign rf_wdata  = r_result;
   assign halted    = r_halted;
   assign illegal   = r_illegal;

   always_comb begin
      w_alu = '0;
      case (w_op)
         4'h1:    w_alu = rs_data + rt_data;
         4'h2:    w_alu = rs_data - rt_data;
         4'h3:    w_alu = rs_data & rt_data;
         4'h4:    w_alu = rs_data | rt_data;
         4'h5:    w_alu = rs_data ^ rt_data;
         4'h6:    w_alu = rs_data << rt_data[3:0];
         4'h7:    w_alu = rs_data >> rt_data[3:0];
         4'h8:    w_alu = rs_data + w_imm6;
         4'h9:    w_alu = {7'd0, r_ir[8:0]};
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_result   <= '0;
         r_rf_write <= 1'b0;
         r_halted   <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_rf_write <= 1'b0;
         case (r_state)
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
               r_ir    <= imem_data;
               r_state <= S_READ;
            end
            // rf_write stays low here so the register file captures rs/rt this cycle.
            S_READ:   r_state <= S_EXEC;
            S_EXEC: begin
               case (w_op)
                  4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                     r_result   <= w_alu;
                     r_rf_write <= 1'b1;
                     r_state    <= S_WB;
                  end
                  4'hA: begin
                     r_pc    <= (rs_data == 16'd0) ? w_br_tgt : w_pc_inc;
                     r_state <= S_FETCH;
                  end
                  4'hB: begin
                     r_pc    <= w_jmp_tgt;
                     r_state <= S_FETCH;
                  end
                  4'hF: begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALTED;
                  end
                  4'hC, 4'hD, 4'hE: begin
                     r_illegal <= 1'b1;
                     r_pc      <= w_pc_inc;
                     r_state   <= S_FETCH;
                  end
                  default: begin
                     r_pc    <= w_pc_inc;
                     r_state <= S_FETCH;
                  end
               endcase
            end
            S_WB: begin
               r_pc    <= w_pc_inc;
               r_state <= S_FETCH;
            end
            S_HALTED: r_state <= S_HALTED;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: sync instruction memory and register file models,
// with write pulses and fetch addresses checked against hand-computed cycle numbers.
module tb_cpu_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [2:0]  rs_addr, rt_addr, rd_addr;
   logic        rf_write;
   logic [15:0] rf_wdata, rs_data, rt_data;
   logic        halted, illegal;

   logic [15:0] mem [0:255];
   logic [15:0] regs [0:7];
   int          cyc;
   int          checks = 0;
   int          failures = 0;

   cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'd0)) dut (
      .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rf_write(rf_write), .rf_wdata(rf_wdata), .rs_data(rs_data), .rt_data(rt_data),
      .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;

   always @(posedge clock) imem_data <= mem[imem_addr];

   // Register file: write when enabled, otherwise refresh registered read data.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         rs_data <= '0;
         rt_data <= '0;
      end else if (rf_write) begin
         regs[rd_addr] <= rf_wdata;
      end else begin
         rs_data <= regs[rs_addr];
         rt_data <= regs[rt_addr];
      end
   end

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      int g = 0;
      while (cyc < n && g < 5000) begin
         @(negedge clock);
         g++;
      end
      chk("sync", cyc, n);
   endtask

   task automatic exp_wr(input string tag, input int n, input logic [2:0] rd, input logic [15:0] d);
      wait_cyc(n - 1);
      chk({tag, "_pre"}, rf_write, 0);
      wait_cyc(n);
      chk({tag, "_we"}, rf_write, 1);
      chk({tag, "_rd"}, rd_addr, rd);
      chk({tag, "_d"}, rf_wdata, d);
      wait_cyc(n + 1);
      chk({tag, "_post"}, rf_write, 0);
   endtask

   task automatic do_reset();
      @(negedge clock) reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock) reset = 1'b0;
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic load_alu_prog();
      clr_mem();
      mem[0]  = 16'h9205; // LI r1,5
      mem[1]  = 16'h9403; // LI r2,3
      mem[2]  = 16'h1650; // ADD r3,r1,r2
      mem[3]  = 16'h2888; // SUB r4,r2,r1
      mem[4]  = 16'h9DF1; // LI r6,0x1F1
      mem[5]  = 16'h6A70; // SHL r5,r1,r6
      mem[6]  = 16'h8E7E; // ADDI r7,r1,-2
      mem[7]  = 16'h5FD8; // XOR r7,r7,r3
      mem[8]  = 16'h7130; // SHR r0,r4,r6
      mem[9]  = 16'h3118; // AND r0,r4,r3
      mem[10] = 16'h4058; // OR r0,r1,r3
      mem[11] = 16'hF000; // HALT
   endtask

   initial begin
      int cnt;
      imem_data = '0;
      clr_mem();

      // Phase A: reset state and ALU program
      load_alu_prog();
      do_reset();
      chk("rst_addr", imem_addr, 0);
      chk("rst_we", rf_write, 0);
      chk("rst_halt", halted, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_wd", rf_wdata, 0);
      wait_cyc(1);
      chk("fetch0", imem_addr, 0);
      exp_wr("li1",   4, 3'd1, 16'h0005);
      exp_wr("li2",   9, 3'd2, 16'h0003);
      exp_wr("add",  14, 3'd3, 16'h0008);
      exp_wr("sub",  19, 3'd4, 16'hFFFE);
      exp_wr("li6",  24, 3'd6, 16'h01F1);
      exp_wr("shl",  29, 3'd5, 16'h000A);
      exp_wr("addi", 34, 3'd7, 16'h0003);
      exp_wr("xor",  39, 3'd7, 16'h000B);
      exp_wr("shr",  44, 3'd0, 16'h7FFF);
      exp_wr("and",  49, 3'd0, 16'h0008);
      exp_wr("or",   54, 3'd0, 16'h000D);
      wait_cyc(58);
      chk("halt_pre", halted, 0);
      wait_cyc(59);
      chk("halt_a", halted, 1);
      chk("halt_a_pc", imem_addr, 11);

      // Phase B: branches and PC wrap
      clr_mem();
      mem[0]   = 16'hB00A; // JMP 10
      mem[8]   = 16'h9201; // LI r1,1
      mem[9]   = 16'h0000; // NOP
      mem[10]  = 16'hA07D; // BEQZ r1,-3
      mem[11]  = 16'hB0FF; // JMP 0xFF
      mem[255] = 16'h0000; // NOP
      do_reset();
      chk("b_halt_clr", halted, 0);
      wait_cyc(4);  chk("jmp10", imem_addr, 10);
      wait_cyc(7);  chk("beqz_hold", imem_addr, 10);
      wait_cyc(8);  chk("beqz_taken", imem_addr, 8);
      exp_wr("b_li1", 12, 3'd1, 16'h0001);
      wait_cyc(13); chk("nop_pc", imem_addr, 9);
      wait_cyc(17); chk("beqz_again", imem_addr, 10);
      wait_cyc(21); chk("beqz_nt", imem_addr, 11);
      wait_cyc(25); chk("jmpff", imem_addr, 8'hFF);
      wait_cyc(29); chk("pc_wrap", imem_addr, 0);
      chk("b_ill", illegal, 0);

      // Phase C: illegal opcode, then HALT holds
      clr_mem();
      mem[0] = 16'hB004; // JMP 4
      mem[4] = 16'hC000; // illegal
      mem[5] = 16'h9407; // LI r2,7
      mem[6] = 16'hF000; // HALT
      do_reset();
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         wait_cyc(n);
         cnt += int'(rf_write);
      end
      chk("ill_pre", illegal, 0);
      wait_cyc(8);
      chk("ill_set", illegal, 1);
      chk("ill_next", imem_addr, 5);
      chk("ill_nowr", cnt + int'(rf_write), 0);
      exp_wr("c_li2", 12, 3'd2, 16'h0007);
      wait_cyc(17);
      chk("halt_c", halted, 1);
      chk("halt_c_pc", imem_addr, 6);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         cnt += int'(rf_write);
         if (imem_addr != 8'd6) cnt += 100;
      end
      chk("halt_nowr", cnt, 0);
      chk("halt_stay", halted, 1);
      chk("ill_sticky", illegal, 1);
      do_reset();
      chk("rst_halt2", halted, 0);
      chk("rst_ill2", illegal, 0);

      // Phase D: reset during WB of ADD
      load_alu_prog();
      do_reset();
      exp_wr("d_li1", 4, 3'd1, 16'h0005);
      exp_wr("d_li2", 9, 3'd2, 16'h0003);
      wait_cyc(14);
      chk("d_add_we", rf_write, 1);
      chk("d_add_rd", rd_addr, 3);
      reset = 1'b1;
      @(negedge clock);
      chk("d_rst_we", rf_write, 0);
      chk("d_rst_pc", imem_addr, 0);
      reset = 1'b0;
      exp_wr("d_restart", 4, 3'd1, 16'h0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
